// File: rtl/conv_layer_output_buffer_pkg.sv
// Shared conv-layer geometry and the column-to-slice helper used by the
// input line buffer and the output row buffer.
package conv_layer_output_buffer_pkg;

    localparam int unsigned CONV_IMAGE_SIZE  = 8;
    localparam int unsigned CONV_KERNEL_SIZE = 3;
    localparam int unsigned CONV_DATA_WIDTH  = 32;
    localparam int unsigned CONV_OUT_SIZE    = CONV_IMAGE_SIZE - CONV_KERNEL_SIZE + 1;
    localparam int unsigned CONV_COL_WIDTH   = 3;

    // Column 0 sits at the MSB end of a packed row.
    function automatic int unsigned elem_lsb(input int unsigned col,
                                             input int unsigned n,
                                             input int unsigned w);
        return (n - 1 - col) * w;
    endfunction

endpackage

// File: rtl/conv_row_serializer.sv
// Walks one buffered row element by element, tracking column/row within a
// frame and pulsing frame_done after the last beat of the frame.
module conv_row_serializer
    import conv_layer_output_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CONV_DATA_WIDTH,
    parameter int unsigned OUT_SIZE   = CONV_OUT_SIZE,
    parameter int unsigned COL_WIDTH  = CONV_COL_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [OUT_SIZE*DATA_WIDTH-1:0] row_data,
    input  logic                           valid,
    input  logic                           data_ready,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic [COL_WIDTH-1:0]           out_col,
    output logic [COL_WIDTH-1:0]           out_row,
    output logic                           frame_done,
    output logic                           pop
);

    logic beat;
    logic last_col;
    logic last_row;

    assign beat     = valid & data_ready;
    assign last_col = (out_col == COL_WIDTH'(OUT_SIZE - 1));
    assign last_row = (out_row == COL_WIDTH'(OUT_SIZE - 1));
    assign pop      = beat & last_col;
    assign data_out = row_data[elem_lsb(32'(out_col), OUT_SIZE, DATA_WIDTH) +: DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_col    <= '0;
            out_row    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= pop & last_row;
            if (beat) begin
                if (last_col) begin
                    out_col <= '0;
                    out_row <= last_row ? '0 : out_row + 1'b1;
                end else begin
                    out_col <= out_col + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/conv_layer_output_buffer.sv
// Two-slot ping-pong row buffer that accepts whole conv output rows and
// streams them one element per beat to the next layer.
module conv_layer_output_buffer
    import conv_layer_output_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CONV_DATA_WIDTH,
    parameter int unsigned OUT_SIZE   = CONV_OUT_SIZE,
    parameter int unsigned COL_WIDTH  = CONV_COL_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           row_valid,
    input  logic [OUT_SIZE*DATA_WIDTH-1:0] row_data,
    output logic                           row_ready,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic                           data_valid,
    input  logic                           data_ready,
    output logic [COL_WIDTH-1:0]           out_col,
    output logic [COL_WIDTH-1:0]           out_row,
    output logic                           frame_done
);

    logic [OUT_SIZE*DATA_WIDTH-1:0] slot [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;

    // Ready depends only on count, so a pop never frees a slot in the same cycle.
    assign row_ready  = (count != 2'd2);
    assign data_valid = (count != 2'd0);
    assign push       = row_valid & row_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= row_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    conv_row_serializer #(
        .DATA_WIDTH(DATA_WIDTH),
        .OUT_SIZE  (OUT_SIZE),
        .COL_WIDTH (COL_WIDTH)
    ) u_serializer (
        .clk       (clk),
        .rst       (rst),
        .row_data  (slot[rd_ptr]),
        .valid     (data_valid),
        .data_ready(data_ready),
        .data_out  (data_out),
        .out_col   (out_col),
        .out_row   (out_row),
        .frame_done(frame_done),
        .pop       (pop)
    );

endmodule

// File: tb/tb_conv_layer_output_buffer.sv
// Scoreboard bench: accepted rows expand into expected beats in a queue; a
// negedge monitor compares every DUT cycle against that queue.
module tb_conv_layer_output_buffer;

    localparam int DW = 32;
    localparam int N  = 6;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            row_valid = 1'b0;
    logic [N*DW-1:0] row_data = '0;
    logic            data_ready = 1'b0;
    logic            row_ready;
    logic [DW-1:0]   data_out;
    logic            data_valid;
    logic [CW-1:0]   out_col;
    logic [CW-1:0]   out_row;
    logic            frame_done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [DW-1:0] d;
        int            col;
        int            row;
    } beat_t;

    beat_t exp_q[$];
    int    model_row = 0;
    bit    fd_exp = 1'b0;

    conv_layer_output_buffer #(
        .DATA_WIDTH(DW),
        .OUT_SIZE  (N),
        .COL_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_valid (row_valid),
        .row_data  (row_data),
        .row_ready (row_ready),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .out_col   (out_col),
        .out_row   (out_row),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: inputs change at posedge+1, so negedge values are
    // exactly what the DUT will act on at the next posedge.
    always @(negedge clk) begin : monitor
        beat_t b;
        bit    fd_next;
        if (rst) begin
            exp_q.delete();
            model_row = 0;
            fd_exp    = 1'b0;
        end else begin
            check("data_valid", 32'(data_valid), 32'(exp_q.size() != 0));
            check("row_ready", 32'(row_ready), 32'(((exp_q.size() + N - 1) / N) != 2));
            check("frame_done", 32'(frame_done), 32'(fd_exp));
            fd_next = 1'b0;
            if (exp_q.size() != 0) begin
                b = exp_q[0];
                check("data_out", data_out, b.d);
                check("out_col", 32'(out_col), b.col);
                check("out_row", 32'(out_row), b.row);
                if (data_ready) begin
                    void'(exp_q.pop_front());
                    fd_next = (b.col == N - 1) && (b.row == N - 1);
                end
            end else begin
                check("idle_col", 32'(out_col), 0);
                check("idle_row", 32'(out_row), model_row);
            end
            fd_exp = fd_next;
            if (row_valid && row_ready) begin
                for (int c = 0; c < N; c++) begin
                    b.d   = row_data[(N - 1 - c) * DW +: DW];
                    b.col = c;
                    b.row = model_row;
                    exp_q.push_back(b);
                end
                model_row = (model_row + 1) % N;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [N*DW-1:0] rand_row();
        logic [N*DW-1:0] r;
        for (int c = 0; c < N; c++) r[(N - 1 - c) * DW +: DW] = $urandom;
        return r;
    endfunction

    task automatic send_row(input logic [N*DW-1:0] r);
        bit ok;
        ok        = 1'b0;
        row_data  = r;
        row_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = row_ready;
            @(posedge clk);
            #1;
        end
        row_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_row: got no row_ready expected acceptance within 200 cycles");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [N*DW-1:0] r;
        bit found;

        tick(2);
        rst = 1'b0;
        @(negedge clk);
        check("reset_data_out", data_out, 32'h0);
        check("reset_row_ready", 32'(row_ready), 32'd1);
        tick(1);

        // Single row 1.0 .. 6.0
        data_ready = 1'b1;
        r = {32'h3F800000, 32'h40000000, 32'h40400000,
             32'h40800000, 32'h40A00000, 32'h40C00000};
        send_row(r);
        tick(10);

        // Backpressure, ignored third row, then toggling ready
        data_ready = 1'b0;
        send_row(rand_row());
        send_row(rand_row());
        row_data  = rand_row();
        row_valid = 1'b1;
        tick(5);
        row_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            data_ready = ~data_ready;
            tick(1);
        end
        data_ready = 1'b1;
        tick(5);

        // Push lands on the same edge as the last beat of the current row
        send_row(rand_row());
        tick(4);
        send_row(rand_row());
        tick(10);

        // Full frame plus first row of the next frame
        do_reset();
        data_ready = 1'b1;
        for (int i = 0; i < N + 1; i++) send_row(rand_row());
        tick(20);

        // Reset mid-stream with a row queued
        do_reset();
        for (int i = 0; i < 4; i++) send_row(rand_row());
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = data_valid && (out_row == 3'd2) && (out_col == 3'd3);
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL midstream_wait: got no beat (2,3) expected one within 100 cycles");
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);
        send_row(rand_row());
        tick(10);

        // Empty idle with ready high
        tick(20);

        // Randomized traffic
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    send_row(rand_row());
                    tick($urandom_range(0, 3));
                end
            end
            begin
                for (int i = 0; i < 600; i++) begin
                    data_ready = ($urandom_range(0, 1) == 1);
                    tick(1);
                end
            end
        join
        data_ready = 1'b1;
        tick(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_layer_output_buffer.md
Name: conv_layer_output_buffer

Overview:
- Parallel-to-serial row buffer at the output of the conv layer; the opposite direction of the layer's serial-to-parallel input line buffer.
- Accepts one full output row (OUT_SIZE results) per handshake from the conv compute array.
- Holds up to two rows in ping-pong slots and streams them one element per beat, with column/row indices, to the next layer (pooling or memory writer).
- Signals end of each output feature map.

Parameters:
DATA_WIDTH, 32, width of one element (IEEE single, treated as opaque bits)
OUT_SIZE, 6, elements per output row and rows per frame (IMAGE_SIZE 8 - KERNEL_SIZE 3 + 1)
COL_WIDTH, 3, width of column/row index outputs; must satisfy 2**COL_WIDTH >= OUT_SIZE

Ports:
clk  input  1  clock; one clock domain
rst  input  1  synchronous, active-high reset
row_valid  input  1  row_data holds a complete output row
row_data  input  OUT_SIZE*DATA_WIDTH  packed row; column 0 at [OUT_SIZE*DATA_WIDTH-1 -: DATA_WIDTH], column OUT_SIZE-1 at [DATA_WIDTH-1 -: DATA_WIDTH]
row_ready  output  1  a free slot exists; a row is accepted when row_valid & row_ready
data_out  output  DATA_WIDTH  current element
data_valid  output  1  data_out, out_col and out_row are valid
data_ready  input  1  downstream accepts; a beat transfers when data_valid & data_ready
out_col  output  COL_WIDTH  column index of data_out
out_row  output  COL_WIDTH  row index within frame of data_out
frame_done  output  1  one-cycle pulse after the final beat of a frame

Behaviour:
- Reset (rst=1 at a clk edge), mid-operation included:
  - count=0, wr_ptr=0, rd_ptr=0, col=0, row=0.
  - row_ready=1, data_valid=0, out_col=0, out_row=0, frame_done=0.
  - data_out and slot contents are 0.
  - Any row or beat in flight is discarded.
- Storage: two slots slot[0..1] of OUT_SIZE*DATA_WIDTH bits; 1-bit wr_ptr and rd_ptr; count 0..2.
- row_ready = (count != 2); a function of registers only, with no combinational path from data_ready.
- Push (row_valid & row_ready): slot[wr_ptr] <= row_data; wr_ptr toggles.
- data_valid = (count != 0).
- data_out = element col of slot[rd_ptr]; combinational mux from registers, zero-cycle latency from col.
- out_col = col; out_row = row.
- Beat (data_valid & data_ready):
  - If col < OUT_SIZE-1: col increments.
  - Else: col <= 0, pop (rd_ptr toggles), then:
    - if row == OUT_SIZE-1: row <= 0 and frame_done=1 in the next cycle;
    - otherwise row increments.
- Simultaneous push and pop in one cycle: count unchanged, both pointers toggle.
- Full (count=2): row_ready=0, even if a pop occurs that cycle. Push-through when full is not supported.
- Empty: data_valid=0; col/row hold; data_out is don't-care but stable from registers.
- Latency: a row pushed into an empty buffer at edge N gives data_valid=1 and col=0 in the cycle after edge N.
- Throughput: a full frame streams in OUT_SIZE*OUT_SIZE beats when data_ready is held high and rows arrive early enough.
- data_valid low with data_ready high: no state change.
- Outputs hold stable while data_valid=1 and data_ready=0 (stall).
- Row and frame counters wrap back to 0 with no idle gap; the next frame's rows may already be buffered.

Decomposition:
- Shared conv package holds: DATA_WIDTH, OUT_SIZE (derived from IMAGE_SIZE and KERNEL_SIZE), COL_WIDTH, and an element-select helper function (column index -> packed slice, column 0 at MSB) shared with the input buffer.
- One natural sub-module: conv_row_serializer, which holds the col/row counters, element mux and frame_done.
- The two-slot storage and pointers stay in the top level.

Test Plan:
- Reset then single row: push a row with elements 0x3F800000..0x40C00000 (1.0..6.0) with data_ready=1 -> data_valid rises the next cycle; 6 beats with out_col 0..5, out_row 0, data_out 1.0..6.0 in order; then data_valid=0.
- Backpressure: push two rows, hold data_ready=0 -> row_ready=0 after the second push and a third row_valid is ignored. Toggle data_ready every cycle -> 12 beats in order with no duplicate or skipped element; data_out stable while stalled.
- Simultaneous push/pop: with count=1, push on the same cycle as the last beat of the current row -> count stays 1; the next beat is out_col=0 of the new row; out_row increments.
- Full frame: 6 rows with data_ready=1 -> 36 beats, out_row 0..5; frame_done pulses exactly once, in the cycle after beat (5,5). The next frame's first beat has out_row=0, out_col=0.
- Reset mid-stream: assert rst at out_col=3 of row 2 with one row queued -> next cycle data_valid=0, row_ready=1, out_col=out_row=0. A new push then streams from (0,0).
- Empty idle: data_ready=1 with no push for 20 cycles -> data_valid stays 0; frame_done stays 0; counters unchanged.
